vit_tb_control: RTL and testbench

VIT_TB_CONTROL -- requirements
Module: vit_tb_control

---
 rtl/vit_tb_control.sv | 146 ++++++++++++++
 tb/tb_vit_tb_control.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vit_tb_control.sv
// Viterbi traceback controller: survivor storage, metric normalisation and a
// sliding-window traceback that emits one decoded bit per window.
module vit_tb_control #(
  parameter int unsigned M         = 3,
  parameter int unsigned W         = 4,
  parameter int unsigned T         = 16,
  parameter int unsigned BLOCK_LEN = 256,
  localparam int unsigned S        = 1 << M
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [S*W-1:0] metric_in,
  input  logic [S-1:0]   dec_in,
  output logic [S*W-1:0] metric_out,
  output logic           dx,
  output logic           dx_valid,
  output logic           block_done
);

  localparam int unsigned PW = $clog2(T);
  localparam int unsigned FW = $clog2(T + 1);
  localparam int unsigned CW = $clog2(BLOCK_LEN + 1);
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {ST_WRITE, ST_TRACE, ST_OUT} state_t;

  state_t         state_q, state_d;
  logic [S-1:0]   surv_mem [T];
  logic [PW-1:0]  wr_ptr_q, tb_ptr_q, step_q;
  logic [FW-1:0]  fill_q;
  logic [M-1:0]   tb_state_q, tb_state_d, min_state;
  logic [W-1:0]   min_val;
  logic [CW-1:0]  bit_cnt_q;
  logic [S*W-1:0] metric_norm, metric_rst;
  logic           accept, fill_last, trace_last, blk_last;

  assign accept     = in_valid && in_ready;
  assign fill_last  = (fill_q == FW'(T - 1));
  assign trace_last = (step_q == PW'(T - 2));
  assign blk_last   = (bit_cnt_q == CW'(BLOCK_LEN - 1));

  // Smallest incoming metric; strict compare keeps the lowest index on ties.
  always_comb begin
    min_state = '0;
    min_val   = metric_in[W-1:0];
    for (int unsigned i = 1; i < S; i++) begin
      if (metric_in[i*W +: W] < min_val) begin
        min_val   = metric_in[i*W +: W];
        min_state = M'(i);
      end
    end
  end

  always_comb begin
    metric_norm = metric_in;
    if (min_val >= HALF) begin
      for (int unsigned i = 0; i < S; i++) begin
        metric_norm[i*W +: W] = metric_in[i*W +: W] - HALF;
      end
    end
  end

  always_comb begin
    metric_rst        = '1;
    metric_rst[W-1:0] = '0;
  end

  // Predecessor state: survivor bit enters at the MSB.
  assign tb_state_d = {surv_mem[tb_ptr_q][tb_state_q], tb_state_q[M-1:1]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WRITE: if (accept && fill_last) state_d = ST_TRACE;
      ST_TRACE: if (trace_last) state_d = ST_OUT;
      ST_OUT:   state_d = ST_WRITE;
      default:  state_d = ST_WRITE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (accept && !reset) surv_mem[wr_ptr_q] <= dec_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_WRITE;
      in_ready   <= 1'b1;
      fill_q     <= '0;
      wr_ptr_q   <= '0;
      tb_ptr_q   <= '0;
      tb_state_q <= '0;
      step_q     <= '0;
      bit_cnt_q  <= '0;
      metric_out <= metric_rst;
      dx         <= 1'b0;
      dx_valid   <= 1'b0;
      block_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready   <= (state_d == ST_WRITE);
      dx_valid   <= 1'b0;
      block_done <= 1'b0;
      case (state_q)
        ST_WRITE: begin
          if (accept) begin
            wr_ptr_q   <= (wr_ptr_q == PW'(T - 1)) ? '0 : wr_ptr_q + PW'(1);
            fill_q     <= fill_q + FW'(1);
            metric_out <= metric_norm;
            if (fill_last) begin
              tb_state_q <= min_state;
              tb_ptr_q   <= wr_ptr_q;
              step_q     <= '0;
            end
          end
        end
        ST_TRACE: begin
          tb_ptr_q   <= (tb_ptr_q == '0) ? PW'(T - 1) : tb_ptr_q - PW'(1);
          tb_state_q <= tb_state_d;
          step_q     <= step_q + PW'(1);
          if (trace_last) begin
            dx         <= tb_state_d[M-1];
            dx_valid   <= 1'b1;
            block_done <= blk_last;
          end
        end
        ST_OUT: begin
          // End of block restarts from reset metrics with an empty window.
          if (block_done) begin
            metric_out <= metric_rst;
            fill_q     <= '0;
            wr_ptr_q   <= '0;
            bit_cnt_q  <= '0;
          end else begin
            fill_q    <= FW'(T - 1);
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vit_tb_control.sv
// Directed bench for vit_tb_control: scoreboarded decoded bits, normalisation,
// tie-breaking, block restart and mid-traceback reset.
module tb_vit_tb_control;

  localparam int unsigned M = 3;
  localparam int unsigned W = 4;
  localparam int unsigned T = 16;
  localparam int unsigned S = 8;

  logic           clock;
  logic           reset;
  logic           in_valid, in_ready, dx, dx_valid, block_done;
  logic [S*W-1:0] metric_in, metric_out;
  logic [S-1:0]   dec_in;
  logic           in_valid_b, in_ready_b, dx_b, dx_valid_b, block_done_b;
  logic [S*W-1:0] metric_in_b, metric_out_b;
  logic [S-1:0]   dec_in_b;

  vit_tb_control dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .metric_in(metric_in), .dec_in(dec_in), .metric_out(metric_out),
    .dx(dx), .dx_valid(dx_valid), .block_done(block_done)
  );

  vit_tb_control #(.BLOCK_LEN(4)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .metric_in(metric_in_b), .dec_in(dec_in_b), .metric_out(metric_out_b),
    .dx(dx_b), .dx_valid(dx_valid_b), .block_done(block_done_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_strobe = 0;
  int last_strobe = 0;
  bit have_last = 0;
  bit gap_chk = 0;
  bit sb_q[$];

  function automatic logic [S*W-1:0] pack8(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7);
    return {W'(a7), W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: bound expired", tag);
  endtask

  // One clock; outputs sampled 1 time unit after the edge; dx scoreboard pop.
  task automatic tick();
    bit e;
    @(posedge clock);
    #1;
    cyc++;
    if (dx_valid === 1'b1) begin
      n_strobe++;
      if (sb_q.size() == 0) begin
        fail_now("dx_unexpected");
      end else begin
        e = sb_q.pop_front();
        chk("dx", 64'(dx), 64'(e));
      end
      chk("block_done_default", 64'(block_done), 64'(0));
      if (gap_chk && have_last) chk("dx_gap", 64'(cyc - last_strobe), 64'(T + 1));
      last_strobe = cyc;
      have_last   = 1;
    end
  endtask

  task automatic accept(input logic [S*W-1:0] m, input logic [S-1:0] d);
    int b;
    metric_in = m;
    dec_in    = d;
    in_valid  = 1'b1;
    b = 0;
    while (in_ready !== 1'b1 && b < 100) begin
      tick();
      b++;
    end
    if (b >= 100) fail_now("accept_wait");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (sb_q.size() != 0 && b < 200) begin
      tick();
      b++;
    end
    if (sb_q.size() != 0) fail_now("drain");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    have_last = 0;
  endtask

  logic [S*W-1:0] rst_m, zero_cw, m;
  logic [S-1:0]   d;
  logic [63:0]    pat;
  logic [2:0]     st [64];
  logic [2:0]     s, ns;
  int             strobes_before, strobe_b, acc_b;
  bit             rst_chk;

  initial begin
    reset = 1'b1;  in_valid = 1'b0;  metric_in = '0;  dec_in = '0;
    in_valid_b = 1'b0;  metric_in_b = '0;  dec_in_b = '0;
    rst_m   = pack8(0, 15, 15, 15, 15, 15, 15, 15);
    zero_cw = rst_m;
    repeat (2) tick();
    reset = 1'b0;

    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_dx_valid", 64'(dx_valid), 64'(0));
    chk("rst_block_done", 64'(block_done), 64'(0));
    chk("rst_dx", 64'(dx), 64'(0));
    chk("rst_metrics", 64'(metric_out), 64'(rst_m));
    chk("rst_metrics_b", 64'(metric_out_b), 64'(rst_m));

    // Normalisation: minimum >= 8 subtracts 8, minimum 7 passes through.
    accept(pack8(9, 12, 8, 10, 11, 13, 14, 15), '0);
    chk("norm_sub", 64'(metric_out), 64'(pack8(1, 4, 0, 2, 3, 5, 6, 7)));
    accept(pack8(7, 12, 9, 15, 8, 10, 11, 13), '0);
    chk("norm_keep", 64'(metric_out), 64'(pack8(7, 12, 9, 15, 8, 10, 11, 13)));
    accept(pack8(15, 15, 15, 15, 15, 15, 15, 15), '0);
    chk("norm_max", 64'(metric_out), 64'(pack8(7, 7, 7, 7, 7, 7, 7, 7)));

    // Zero-error all-zero codeword: ready low 16 cycles, dx_valid on the 16th.
    do_reset();
    for (int i = 0; i < 15; i++) accept(zero_cw, '0);
    chk("fill_ready", 64'(in_ready), 64'(1));
    metric_in = zero_cw;  dec_in = '0;  in_valid = 1'b1;
    sb_q.push_back(1'b0);
    tick();
    in_valid = 1'b0;
    chk("busy_ready_1", 64'(in_ready), 64'(0));
    for (int k = 2; k <= 16; k++) begin
      tick();
      chk("busy_ready", 64'(in_ready), 64'(0));
      chk("busy_dx_valid", 64'(dx_valid), 64'(k == 16));
    end
    tick();
    chk("ready_again", 64'(in_ready), 64'(1));
    chk("strobe_one_cycle", 64'(dx_valid), 64'(0));
    chk("zero_cw_metrics", 64'(metric_out), 64'(zero_cw));
    chk("zero_cw_sb", 64'(sb_q.size()), 64'(0));

    // Decisions 0xAA make each trace step a rotate right; 15 rotations of a
    // 3-bit state return the start state, so dx is the start state's MSB.
    do_reset();
    for (int i = 0; i < 15; i++) accept(zero_cw, 8'hAA);
    sb_q.push_back(1'b0);          // tie 2/5 -> start state 2 -> dx 0
    accept(pack8(9, 9, 3, 9, 9, 3, 9, 9), 8'hAA);
    wait_drain();
    sb_q.push_back(1'b1);          // unique minimum at 5 -> dx 1
    accept(pack8(9, 9, 9, 9, 9, 3, 9, 9), 8'hAA);
    wait_drain();

    // Noise-free stream: true-path state gets metric 0 and the correct survivor
    // bit; the traced-back window's oldest-stage state MSB is the decoded bit.
    do_reset();
    pat = 64'hB4F0_93A5_6C1D_E782;
    s = '0;
    gap_chk = 1;
    strobes_before = n_strobe;
    for (int k = 0; k < 64; k++) begin
      ns = {s[1:0], pat[k]};
      st[k] = ns;
      d = S'($urandom);
      d[ns] = s[2];
      for (int i = 0; i < int'(S); i++)
        m[i*W +: W] = (i == int'(ns)) ? '0 : W'($urandom_range(15, 1));
      if (k >= int'(T) - 1) sb_q.push_back(st[k - (int'(T) - 1)][2]);
      accept(m, d);
      s = ns;
    end
    wait_drain();
    gap_chk = 0;
    chk("stream_count", 64'(n_strobe - strobes_before), 64'(64 - T + 1));

    // Reset in the 5th traceback cycle with in_valid high.
    do_reset();
    for (int i = 0; i < 16; i++) accept(zero_cw, '0);
    repeat (4) tick();
    chk("mid_trace_busy", 64'(in_ready), 64'(0));
    reset = 1'b1;  in_valid = 1'b1;  metric_in = pack8(1, 1, 1, 1, 1, 1, 1, 1);
    tick();
    reset = 1'b0;  in_valid = 1'b0;
    chk("midrst_ready", 64'(in_ready), 64'(1));
    chk("midrst_dx_valid", 64'(dx_valid), 64'(0));
    chk("midrst_block_done", 64'(block_done), 64'(0));
    chk("midrst_metrics", 64'(metric_out), 64'(rst_m));
    chk("midrst_dx", 64'(dx), 64'(0));
    for (int i = 0; i < 15; i++) accept(zero_cw, '0);
    chk("midrst_no_accept", 64'(in_ready), 64'(1));
    sb_q.push_back(1'b0);
    accept(zero_cw, '0);
    chk("midrst_refill", 64'(in_ready), 64'(0));
    wait_drain();

    // BLOCK_LEN = 4: done on strobe 4, then reset metrics and a full refill.
    metric_in_b = pack8(1, 14, 14, 14, 14, 14, 14, 14);
    dec_in_b = '0;
    in_valid_b = 1'b1;
    strobe_b = 0;  acc_b = 0;  rst_chk = 0;
    for (int c = 0; c < 800 && strobe_b < 5; c++) begin
      if (in_ready_b === 1'b1) acc_b++;
      tick();
      if (rst_chk) begin
        chk("blk_rst_metrics", 64'(metric_out_b), 64'(rst_m));
        rst_chk = 0;
      end
      if (dx_valid_b === 1'b1) begin
        strobe_b++;
        chk("blk_done", 64'(block_done_b), 64'(strobe_b == 4));
        chk("blk_accepts", 64'(acc_b), 64'((strobe_b == 1 || strobe_b == 5) ? 16 : 1));
        chk("blk_dx", 64'(dx_b), 64'(0));
        acc_b = 0;
        if (strobe_b == 4) rst_chk = 1;
      end else if (block_done_b !== 1'b0) begin
        chk("blk_done_stray", 64'(block_done_b), 64'(0));
      end
    end
    in_valid_b = 1'b0;
    if (strobe_b < 5) fail_now("blk_strobes");

    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
